// File: rtl/wb_select_stage.sv
// Register-writeback stage: selects one of NSRC result slots, extends sub-word
// loads from the data-memory slot and registers the GPR write port. A read from
// the bridge slot stalls the pipeline until bridge_ready rises or a timeout
// expires. A timeout retires the instruction without a write and pulses bus_err.
module wb_select_stage #(
    parameter int DW         = 32,
    parameter int NSRC       = 6,
    parameter int SELW       = 3,
    parameter int ADDRW      = 5,
    parameter int DM_SEL     = 1,
    parameter int BRIDGE_SEL = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SELW-1:0]     in_sel,
    input  logic                in_wr_en,
    input  logic [ADDRW-1:0]    in_wr_addr,
    input  logic [NSRC*DW-1:0]  src_data,
    input  logic [2:0]          ld_type,
    input  logic [1:0]          byte_off,
    input  logic                bridge_ready,
    output logic                stall,
    output logic                wb_valid,
    output logic                wb_wr_en,
    output logic [ADDRW-1:0]    wb_wr_addr,
    output logic [DW-1:0]       wb_data,
    output logic                bus_err
);

    localparam logic [SELW-1:0] DM_IDX     = SELW'(DM_SEL);
    localparam logic [SELW-1:0] BRIDGE_IDX = SELW'(BRIDGE_SEL);
    localparam logic [15:0]     TMO_LIMIT  = 16'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_wr_en_q, wb_wr_en_d;
    logic [ADDRW-1:0]   wb_wr_addr_q, wb_wr_addr_d;
    logic [DW-1:0]      wb_data_q, wb_data_d;
    logic               bus_err_q, bus_err_d;

    logic [DW-1:0]      slot_data [NSRC];
    logic [DW-1:0]      raw_data;
    logic [DW-1:0]      ext_data;
    logic [DW-1:0]      sel_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               is_bridge;
    logic               capture;
    logic               timeout_hit;

    // Unpack the flat source bus into one word per slot.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_slot
            assign slot_data[gi] = src_data[gi*DW +: DW];
        end
    endgenerate

    // Slot mux; a select beyond the populated slots yields zero.
    always_comb begin
        raw_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                raw_data = slot_data[k];
            end
        end
    end

    // Little-endian sub-word extraction for the data-memory slot.
    assign ld_byte = raw_data[{byte_off, 3'b000} +: 8];
    assign ld_half = raw_data[{byte_off[1], 4'b0000} +: 16];

    // Load extension: lbu/lhu zero-extend, lb/lh sign-extend, anything else is a full word.
    always_comb begin
        ext_data = raw_data;
        case (ld_type)
            3'b001:  ext_data = {{(DW-8){1'b0}}, ld_byte};
            3'b010:  ext_data = {{(DW-8){ld_byte[7]}}, ld_byte};
            3'b011:  ext_data = {{(DW-16){1'b0}}, ld_half};
            3'b100:  ext_data = {{(DW-16){ld_half[15]}}, ld_half};
            default: ext_data = raw_data;
        endcase
    end

    assign sel_data  = (in_sel == DM_IDX) ? ext_data : raw_data;
    assign is_bridge = (in_sel == BRIDGE_IDX);

    // Bridge-wait FSM: next state, wait counter, stall and capture decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_bridge && !bridge_ready) begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = 16'd1;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Ready is checked first so a late response still beats the timeout.
                if (bridge_ready) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q < TMO_LIMIT) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Writeback register next values; address and data hold when nothing retires.
    always_comb begin
        wb_valid_d   = capture | timeout_hit;
        wb_wr_en_d   = capture & in_wr_en & (in_wr_addr != '0);
        wb_wr_addr_d = capture ? in_wr_addr : wb_wr_addr_q;
        wb_data_d    = wb_data_q;
        if (capture) begin
            wb_data_d = sel_data;
        end else if (timeout_hit) begin
            wb_data_d = '0;
        end
        bus_err_d    = timeout_hit;
    end

    // State and writeback registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            wb_valid_q   <= 1'b0;
            wb_wr_en_q   <= 1'b0;
            wb_wr_addr_q <= '0;
            wb_data_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wb_valid_q   <= wb_valid_d;
            wb_wr_en_q   <= wb_wr_en_d;
            wb_wr_addr_q <= wb_wr_addr_d;
            wb_data_q    <= wb_data_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_wr_en   = wb_wr_en_q;
    assign wb_wr_addr = wb_wr_addr_q;
    assign wb_data    = wb_data_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage with a short bridge timeout (4). Expected values come
// from a word-level model of slot selection / load extension and from the
// stall-count rule for bridge reads (ready after k low cycles => min(k, TIMEOUT)
// stall cycles, then either a capture or a timeout retirement).
module tb_wb_select_stage;

    localparam int DW   = 32;
    localparam int NSRC = 6;
    localparam int TMO  = 4;
    localparam int BSEL = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [2:0]        in_sel;
    logic              in_wr_en;
    logic [4:0]        in_wr_addr;
    logic [NSRC*DW-1:0] src_data;
    logic [2:0]        ld_type;
    logic [1:0]        byte_off;
    logic              bridge_ready;
    logic              stall;
    logic              wb_valid;
    logic              wb_wr_en;
    logic [4:0]        wb_wr_addr;
    logic [DW-1:0]     wb_data;
    logic              bus_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model of the held writeback address/data.
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    wb_select_stage #(
        .DW(DW), .NSRC(NSRC), .SELW(3), .ADDRW(5),
        .DM_SEL(1), .BRIDGE_SEL(BSEL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sel(in_sel),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .src_data(src_data),
        .ld_type(ld_type), .byte_off(byte_off), .bridge_ready(bridge_ready),
        .stall(stall), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en),
        .wb_wr_addr(wb_wr_addr), .wb_data(wb_data), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Word-level reference for the value a capture writes.
    function automatic logic [31:0] ref_result(input int sel, input logic [NSRC*DW-1:0] src,
                                               input logic [2:0] ld, input logic [1:0] off);
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        if (sel >= NSRC) return 32'd0;
        w = src[sel*32 +: 32];
        if (sel != 1) return w;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (ld)
            3'd1: return b;
            3'd2: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd3: return h;
            3'd4: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            default: return w;
        endcase
    endfunction

    function automatic logic [NSRC*DW-1:0] rand_src();
        logic [NSRC*DW-1:0] s;
        for (int k = 0; k < NSRC; k++) s[k*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic apply(input logic v, input int sel, input logic we, input logic [4:0] a,
                         input logic [NSRC*DW-1:0] s, input logic [2:0] ld,
                         input logic [1:0] off, input logic rdy);
        in_valid     = v;
        in_sel       = 3'(sel);
        in_wr_en     = we;
        in_wr_addr   = a;
        src_data     = s;
        ld_type      = ld;
        byte_off     = off;
        bridge_ready = rdy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        apply(1'b1, 0, 1'b1, 5'd3, rand_src(), 3'd0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (wb_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
        vectors++; if (wb_wr_en !== 1'b0)   begin miscompares++; $display("FAIL reset_wr_en got=%b exp=0", wb_wr_en); end
        vectors++; if (wb_wr_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", wb_wr_addr); end
        vectors++; if (wb_data !== 32'd0)   begin miscompares++; $display("FAIL reset_data got=%h exp=0", wb_data); end
        vectors++; if (bus_err !== 1'b0)    begin miscompares++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
        reset = 1'b0;
        in_valid = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        $display("txn reset done");
    endtask

    task automatic test_directed();
        logic [NSRC*DW-1:0] s;
        logic [2:0]  lds  [5] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd0};
        logic [1:0]  offs [5] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
        int          sels [5] = '{0, 1, 1, 1, 0};
        logic [4:0]  addrs[5] = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
        logic [31:0] exps [5] = '{32'h0000_1234, 32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_1234};
        s = rand_src();
        s[0*32 +: 32] = 32'h0000_1234;
        s[1*32 +: 32] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, sels[i], 1'b1, addrs[i], s, lds[i], offs[i], 1'b0);
            @(negedge clk);
            vectors++; if (wb_data !== exps[i]) begin miscompares++; $display("FAIL dir%0d_data got=%h exp=%h", i, wb_data, exps[i]); end
            vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL dir%0d_valid got=%b exp=1", i, wb_valid); end
            vectors++; if (wb_wr_en !== (addrs[i] != 5'd0)) begin miscompares++; $display("FAIL dir%0d_wr_en got=%b exp=%b", i, wb_wr_en, addrs[i] != 5'd0); end
            $display("txn directed %0d data=%h", i, wb_data);
        end
        m_addr = 5'd0;
        m_data = 32'h0000_1234;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NSRC*DW-1:0] s;
        logic v, we, rdy;
        int sel;
        logic [4:0] a;
        logic [2:0] ld;
        logic [1:0] off;
        for (int i = 0; i < 60; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            we  = $urandom_range(0, 1) == 1;
            a   = 5'($urandom_range(0, 31));
            ld  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            rdy = (sel == BSEL) ? 1'b1 : ($urandom_range(0, 1) == 1);
            s   = rand_src();
            apply(v, sel, we, a, s, ld, off, rdy);
            #1;
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_stall got=%b exp=0", i, stall); end
            if (v) begin
                m_addr = a;
                m_data = ref_result(sel, s, ld, off);
            end
            @(negedge clk);
            vectors++; if (wb_valid !== v) begin miscompares++; $display("FAIL rnd%0d_valid got=%b exp=%b", i, wb_valid, v); end
            vectors++; if (wb_wr_en !== (v && we && a != 5'd0)) begin miscompares++; $display("FAIL rnd%0d_wr_en got=%b exp=%b", i, wb_wr_en, v && we && a != 5'd0); end
            vectors++; if (wb_wr_addr !== m_addr) begin miscompares++; $display("FAIL rnd%0d_addr got=%0d exp=%0d", i, wb_wr_addr, m_addr); end
            vectors++; if (wb_data !== m_data) begin miscompares++; $display("FAIL rnd%0d_data got=%h exp=%h", i, wb_data, m_data); end
            $display("txn random %0d v=%b sel=%0d ld=%0d off=%0d data=%h", i, v, sel, ld, off, wb_data);
        end
        in_valid = 1'b0;
    endtask

    // Bridge read whose ready arrives after k low cycles (k > TMO means never).
    task automatic do_bridge(input int k, input logic [31:0] d, input logic we, input logic [4:0] a);
        logic [NSRC*DW-1:0] s;
        int last;
        s = rand_src();
        s[BSEL*32 +: 32] = d;
        last = (k < TMO) ? k : TMO;
        apply(1'b1, BSEL, we, a, s, 3'd0, 2'd0, k == 0);
        for (int c = 0; c <= last; c++) begin
            #1;
            vectors++; if (stall !== (c != last)) begin miscompares++; $display("FAIL br_k%0d_c%0d_stall got=%b exp=%b", k, c, stall, c != last); end
            if (c > 0) begin
                vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL br_k%0d_c%0d_valid got=%b exp=0", k, c, wb_valid); end
            end
            if (c < last) begin
                @(negedge clk);
                bridge_ready = (c + 1 == k);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        bridge_ready = 1'b0;
        if (k <= TMO) begin
            m_addr = a;
            m_data = d;
        end else begin
            m_data = 32'd0;
        end
        vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL br_k%0d_valid got=%b exp=1", k, wb_valid); end
        vectors++; if (wb_wr_en !== (k <= TMO && we && a != 5'd0)) begin miscompares++; $display("FAIL br_k%0d_wr_en got=%b exp=%b", k, wb_wr_en, k <= TMO && we && a != 5'd0); end
        vectors++; if (wb_wr_addr !== m_addr) begin miscompares++; $display("FAIL br_k%0d_addr got=%0d exp=%0d", k, wb_wr_addr, m_addr); end
        vectors++; if (wb_data !== m_data) begin miscompares++; $display("FAIL br_k%0d_data got=%h exp=%h", k, wb_data, m_data); end
        vectors++; if (bus_err !== (k > TMO)) begin miscompares++; $display("FAIL br_k%0d_bus_err got=%b exp=%b", k, bus_err, k > TMO); end
        $display("txn bridge k=%0d data=%h bus_err=%b", k, wb_data, bus_err);
        @(negedge clk);
        #1;
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL br_k%0d_err_pulse got=%b exp=0", k, bus_err); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL br_k%0d_idle_valid got=%b exp=0", k, wb_valid); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL br_k%0d_idle_stall got=%b exp=0", k, stall); end
    endtask

    task automatic test_bridge_wait();
        do_bridge(3, 32'h0000_CAFE, 1'b1, 5'd7);
        do_bridge(0, 32'h1357_9BDF, 1'b1, 5'd12);
    endtask

    task automatic test_timeout();
        do_bridge(1000, 32'hDEAD_BEEF, 1'b1, 5'd4);
        do_bridge(TMO + 1, 32'h0BAD_F00D, 1'b1, 5'd5);
        // FSM must be back in IDLE: a plain ALU op captures without stalling.
        apply(1'b1, 0, 1'b1, 5'd6, rand_src(), 3'd0, 2'd0, 1'b0);
        src_data[31:0] = 32'h0000_4321;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL post_tmo_stall got=%b exp=0", stall); end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (wb_data !== 32'h0000_4321) begin miscompares++; $display("FAIL post_tmo_data got=%h exp=00004321", wb_data); end
        m_addr = 5'd6;
        m_data = 32'h0000_4321;
        $display("txn post-timeout alu data=%h", wb_data);
    endtask

    task automatic test_ready_at_timeout();
        do_bridge(TMO, 32'hA5A5_0F0F, 1'b1, 5'd20);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            do_bridge($urandom_range(0, TMO + 2), $urandom, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        apply(1'b1, BSEL, 1'b1, 5'd9, rand_src(), 3'd0, 2'd0, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rw_enter_stall got=%b exp=1", stall); end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0)    begin miscompares++; $display("FAIL rw_stall got=%b exp=0", stall); end
        vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rw_valid got=%b exp=0", wb_valid); end
        bridge_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rw_late_ready%0d_valid got=%b exp=0", c, wb_valid); end
            vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("FAIL rw_late_ready%0d_data got=%h exp=0", c, wb_data); end
        end
        bridge_ready = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        $display("txn reset-in-wait done");
    endtask

    initial begin
        reset = 1'b1;
        apply(1'b0, 0, 1'b0, 5'd0, '0, 3'd0, 2'd0, 1'b0);
        test_reset();
        test_directed();
        test_random();
        test_bridge_wait();
        test_timeout();
        test_ready_at_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
